dispensa_sequencer: RTL and testbench

DISPENSA_SEQUENCER -- requirements
Module: dispensa_sequencer

---
 rtl/dispensa_sequencer.sv | 146 ++++++++++++++
 tb/tb_dispensa_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispensa_sequencer.sv
// Beverage dispense sequencer: cup drop, heating, grinding, water and milk phases.
// Moore FSM with a shared dwell counter cleared on every state entry.
module dispensa_sequencer #(
    parameter int unsigned T_COPO       = 4,
    parameter int unsigned T_MOE        = 6,
    parameter int unsigned T_AGUA       = 8,
    parameter int unsigned T_LEITE      = 5,
    parameter int unsigned T_AQUECE_MAX = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inicia,
    input  logic [1:0] selec_produto,
    input  logic       agua_ok,
    input  logic       temp_ok,
    input  logic       limpa_erro,
    output logic       copo,
    output logic       aquecedor,
    output logic       moedor,
    output logic       valvula_agua,
    output logic       valvula_leite,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro
);

    typedef enum logic [2:0] {
        StOcioso,
        StCopo,
        StAquece,
        StMoe,
        StAgua,
        StLeite,
        StFim,
        StErro
    } state_e;

    localparam logic [1:0] ProdCafe      = 2'b00;
    localparam logic [1:0] ProdCafeLeite = 2'b01;
    localparam logic [1:0] ProdCha       = 2'b10;

    // Counter value on the last cycle of each timed phase.
    localparam logic [7:0] LastCopo   = 8'(T_COPO - 1);
    localparam logic [7:0] LastMoe    = 8'(T_MOE - 1);
    localparam logic [7:0] LastAgua   = 8'(T_AGUA - 1);
    localparam logic [7:0] LastLeite  = 8'(T_LEITE - 1);
    localparam logic [7:0] LastAquece = 8'(T_AQUECE_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] prod_q, prod_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StOcioso;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOcioso: begin
                if (inicia) begin
                    state_d = agua_ok ? StCopo : StErro;
                end
            end
            StCopo: begin
                if (cnt_q == LastCopo) state_d = StAquece;
            end
            StAquece: begin
                // A temperature hit on the timeout cycle still wins.
                if (temp_ok) begin
                    if (prod_q == ProdCafe || prod_q == ProdCafeLeite) begin
                        state_d = StMoe;
                    end else if (prod_q == ProdCha) begin
                        state_d = StAgua;
                    end else begin
                        state_d = StLeite;
                    end
                end else if (cnt_q == LastAquece) begin
                    state_d = StErro;
                end
            end
            StMoe: begin
                if (cnt_q == LastMoe) state_d = StAgua;
            end
            StAgua: begin
                if (!agua_ok) begin
                    state_d = StErro;
                end else if (cnt_q == LastAgua) begin
                    state_d = (prod_q == ProdCafeLeite) ? StLeite : StFim;
                end
            end
            StLeite: begin
                if (cnt_q == LastLeite) state_d = StFim;
            end
            StFim: begin
                state_d = StOcioso;
            end
            StErro: begin
                if (limpa_erro) state_d = StOcioso;
            end
            default: begin
                state_d = StOcioso;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q || state_q == StOcioso || state_q == StErro) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        prod_d = (state_q == StOcioso && inicia) ? selec_produto : prod_q;
    end

    always_comb begin
        copo          = 1'b0;
        aquecedor     = 1'b0;
        moedor        = 1'b0;
        valvula_agua  = 1'b0;
        valvula_leite = 1'b0;
        ocupado       = 1'b1;
        pronto        = 1'b0;
        erro          = 1'b0;
        case (state_q)
            StOcioso: ocupado       = 1'b0;
            StCopo:   copo          = 1'b1;
            StAquece: aquecedor     = 1'b1;
            StMoe:    moedor        = 1'b1;
            StAgua:   valvula_agua  = 1'b1;
            StLeite:  valvula_leite = 1'b1;
            StFim:    pronto        = 1'b1;
            StErro:   erro          = 1'b1;
            default:  ocupado       = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dispensa_sequencer.sv
// Directed self-checking bench for dispensa_sequencer (default parameters).
module tb_dispensa_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       inicia = 1'b0;
    logic [1:0] selec_produto = 2'b00;
    logic       agua_ok = 1'b1;
    logic       temp_ok = 1'b0;
    logic       limpa_erro = 1'b0;
    logic       copo, aquecedor, moedor, valvula_agua, valvula_leite, ocupado, pronto, erro;
    logic [7:0] outs;

    int tests = 0;
    int fails = 0;
    // Cycle counters: copo, aquecedor, moedor, agua, leite, ocupado, pronto, multi-actuator.
    int cnt [8];

    dispensa_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .inicia        (inicia),
        .selec_produto (selec_produto),
        .agua_ok       (agua_ok),
        .temp_ok       (temp_ok),
        .limpa_erro    (limpa_erro),
        .copo          (copo),
        .aquecedor     (aquecedor),
        .moedor        (moedor),
        .valvula_agua  (valvula_agua),
        .valvula_leite (valvula_leite),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .erro          (erro)
    );

    assign outs = {copo, aquecedor, moedor, valvula_agua, valvula_leite, ocupado, pronto, erro};

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (copo)          cnt[0] <= cnt[0] + 1;
            if (aquecedor)     cnt[1] <= cnt[1] + 1;
            if (moedor)        cnt[2] <= cnt[2] + 1;
            if (valvula_agua)  cnt[3] <= cnt[3] + 1;
            if (valvula_leite) cnt[4] <= cnt[4] + 1;
            if (ocupado)       cnt[5] <= cnt[5] + 1;
            if (pronto)        cnt[6] <= cnt[6] + 1;
            if (int'(copo) + int'(aquecedor) + int'(moedor) + int'(valvula_agua)
                + int'(valvula_leite) > 1) cnt[7] <= cnt[7] + 1;
        end
    end

    function automatic logic [63:0] delta(input int base [8]);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[63-8*i -: 8] = 8'(cnt[i] - base[i]);
        return d;
    endfunction

    task automatic pulse_inicia(input logic [1:0] p);
        @(negedge clock);
        selec_produto = p;
        inicia = 1'b1;
        @(negedge clock);
        inicia = 1'b0;
    endtask

    task automatic pulse_limpa();
        @(negedge clock);
        limpa_erro = 1'b1;
        @(negedge clock);
        limpa_erro = 1'b0;
    endtask

    // Wait (bounded) at falling edges until outs[idx] == val.
    task automatic wait_for(input int idx, input logic val, input int budget, input string name);
        int b = 0;
        while (outs[idx] !== val && b < budget) begin
            @(negedge clock);
            b++;
        end
        tests++;
        if (outs[idx] !== val) begin
            fails++;
            $display("FAIL %s timeout: outs=%b after %0d cycles", name, outs, b);
        end
    endtask

    // Raise temp_ok on the n-th heater cycle (n=0 keeps it low).
    task automatic heat(input int n);
        wait_for(6, 1'b1, 50, "wait_aquecedor");
        if (n > 0) begin
            repeat (n - 1) @(negedge clock);
            temp_ok = 1'b1;
            @(negedge clock);
            temp_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        inicia = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (outs !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00000000", outs);
        end
        inicia = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if (outs !== 8'h00) begin
            fails++;
            $display("FAIL post_reset_idle: got %b want 00000000", outs);
        end
    endtask

    task automatic test_products();
        logic [63:0] exp_tab [4];
        int          base [8];
        exp_tab[0] = {8'd4, 8'd3, 8'd6, 8'd8, 8'd0, 8'd22, 8'd1, 8'd0};
        exp_tab[1] = {8'd4, 8'd3, 8'd6, 8'd8, 8'd5, 8'd27, 8'd1, 8'd0};
        exp_tab[2] = {8'd4, 8'd3, 8'd0, 8'd8, 8'd0, 8'd16, 8'd1, 8'd0};
        exp_tab[3] = {8'd4, 8'd3, 8'd0, 8'd0, 8'd5, 8'd13, 8'd1, 8'd0};
        for (int p = 0; p < 4; p++) begin
            base = cnt;
            pulse_inicia(2'(p));
            heat(3);
            wait_for(2, 1'b0, 100, "wait_idle_product");
            tests++;
            if (delta(base) !== exp_tab[p]) begin
                fails++;
                $display("FAIL product_%0d counts: got %h want %h", p, delta(base), exp_tab[p]);
            end
        end
    endtask

    task automatic test_timeout();
        int base [8];
        base = cnt;
        pulse_inicia(2'b00);
        heat(0);
        wait_for(0, 1'b1, 40, "wait_erro_timeout");
        repeat (3) @(negedge clock);
        tests++;
        if (outs !== 8'b0000_0101) begin
            fails++;
            $display("FAIL timeout_erro_state: got %b want 00000101", outs);
        end
        tests++;
        if (delta(base) >> 48 !== 64'h0414) begin
            fails++;
            $display("FAIL timeout_counts: got copo/aq %h want 0414", delta(base) >> 48);
        end
        pulse_limpa();
        tests++;
        if (outs !== 8'h00) begin
            fails++;
            $display("FAIL timeout_clear: got %b want 00000000", outs);
        end
    endtask

    task automatic test_agua_drop();
        int base [8];
        base = cnt;
        pulse_inicia(2'b00);
        heat(3);
        wait_for(4, 1'b1, 20, "wait_agua");
        repeat (2) @(negedge clock);
        agua_ok = 1'b0;
        @(negedge clock);
        tests++;
        if (outs !== 8'b0000_0101) begin
            fails++;
            $display("FAIL agua_drop_erro: got %b want 00000101", outs);
        end
        tests++;
        if (delta(base) >> 32 !== 64'h0403_0603) begin
            fails++;
            $display("FAIL agua_drop_counts: got %h want 04030603", delta(base) >> 32);
        end
        agua_ok = 1'b1;
        pulse_limpa();
        tests++;
        if (ocupado !== 1'b0) begin
            fails++;
            $display("FAIL agua_drop_clear: ocupado got %b want 0", ocupado);
        end
    endtask

    task automatic test_no_water();
        int base [8];
        base = cnt;
        agua_ok = 1'b0;
        pulse_inicia(2'b01);
        repeat (4) @(negedge clock);
        tests++;
        if (outs !== 8'b0000_0101) begin
            fails++;
            $display("FAIL no_water_erro: got %b want 00000101", outs);
        end
        tests++;
        if (delta(base) >> 24 !== 64'h0) begin
            fails++;
            $display("FAIL no_water_actuators: got %h want 0", delta(base) >> 24);
        end
        agua_ok = 1'b1;
        pulse_limpa();
    endtask

    task automatic test_ignore_in_moe();
        int base [8];
        base = cnt;
        pulse_inicia(2'b01);
        heat(3);
        tests++;
        if (moedor !== 1'b1) begin
            fails++;
            $display("FAIL ignore_in_moe_phase: moedor got %b want 1", moedor);
        end
        inicia = 1'b1;
        selec_produto = 2'b11;
        @(negedge clock);
        inicia = 1'b0;
        selec_produto = 2'b10;
        wait_for(2, 1'b0, 100, "wait_idle_ignore");
        tests++;
        if (delta(base) !== {8'd4, 8'd3, 8'd6, 8'd8, 8'd5, 8'd27, 8'd1, 8'd0}) begin
            fails++;
            $display("FAIL ignore_in_moe_counts: got %h want 04030608051b0100", delta(base));
        end
        repeat (2) @(negedge clock);
        tests++;
        if (ocupado !== 1'b0) begin
            fails++;
            $display("FAIL ignore_in_moe_no_restart: ocupado got %b want 0", ocupado);
        end
    endtask

    task automatic test_reset_mid_agua();
        int base [8];
        pulse_inicia(2'b00);
        heat(3);
        wait_for(4, 1'b1, 20, "wait_agua_reset");
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        tests++;
        if (valvula_agua !== 1'b0 || ocupado !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: agua=%b ocupado=%b want 0 0", valvula_agua, ocupado);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        base = cnt;
        repeat (10) @(negedge clock);
        tests++;
        if (delta(base) !== 64'h0) begin
            fails++;
            $display("FAIL reset_no_activity: got %h want 0", delta(base));
        end
    endtask

    task automatic test_back_to_back();
        int base [8];
        base = cnt;
        pulse_inicia(2'b10);
        heat(1);
        wait_for(2, 1'b0, 100, "wait_idle_b2b_1");
        tests++;
        if (delta(base) !== {8'd4, 8'd1, 8'd0, 8'd8, 8'd0, 8'd14, 8'd1, 8'd0}) begin
            fails++;
            $display("FAIL b2b_cha counts: got %h want 04010008000e0100", delta(base));
        end
        base = cnt;
        pulse_inicia(2'b11);
        heat(2);
        wait_for(2, 1'b0, 100, "wait_idle_b2b_2");
        tests++;
        if (delta(base) !== {8'd4, 8'd2, 8'd0, 8'd0, 8'd5, 8'd12, 8'd1, 8'd0}) begin
            fails++;
            $display("FAIL b2b_leite counts: got %h want 04020000050c0100", delta(base));
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_timeout();
        test_agua_drop();
        test_no_water();
        test_ignore_in_moe();
        test_reset_mid_agua();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
